// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter.
//
// Sends one command byte to a PS/2 device over the shared open-drain
// PS2_CLK / PS2_DAT lines. The top level pulls a pin low while its *_oe
// output is 1 and releases it (high-Z) otherwise.
//
// Sequence: hold CLK low (inhibit), assert the start bit, release CLK,
// then present data bits LSB first, odd parity and the stop bit on each
// device clock falling edge. The device's ACK is sampled on the next
// falling edge, and the block then waits for the bus to go idle.
//
// Optional build macro: PS2_TX_RETRY_EN -- on the first NACK or timeout
// the same byte is retried once (no error pulse, cmd_busy stays high);
// a second failure pulses cmd_error.
//
// Handshake: cmd_send is a single-cycle request that is accepted only
// while cmd_busy is low (IDLE); cmd_data is sampled in that same cycle.
// cmd_busy rises on the next cycle and falls in the cycle where
// cmd_done or cmd_error pulses (exactly one of them per accepted request).
//
// Ports:
//   clock_50    in   system clock
//   resetn      in   synchronous active-low reset
//   cmd_data    in   [7:0] byte to send
//   cmd_send    in   request strobe
//   ps2_clk_in  in   raw PS2_CLK pin level (asynchronous)
//   ps2_dat_in  in   raw PS2_DAT pin level (asynchronous)
//   ps2_clk_oe  out  1 = pull PS2_CLK low
//   ps2_dat_oe  out  1 = pull PS2_DAT low
//   cmd_busy    out  transfer in progress
//   cmd_done    out  1-cycle pulse: byte sent and acknowledged
//   cmd_error   out  1-cycle pulse: timeout or NACK
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int CNT_W          = 20
) (
    input  logic       clock_50,
    input  logic       resetn,
    input  logic [7:0] cmd_data,
    input  logic       cmd_send,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       cmd_busy,
    output logic       cmd_done,
    output logic       cmd_error
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_WAIT_ACK  = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;
    localparam logic [2:0] S_FAIL      = 3'd7;

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bitcnt;
    logic [8:0]       shreg;

    // Two-flop synchronizers; clk_q holds the previous synced clock level.
    // They reset to 1 (idle bus) so reset release cannot fake an edge.
    logic clk_s1, clk_s2, clk_q;
    logic dat_s1, dat_s2;
    logic fe;

`ifdef PS2_TX_RETRY_EN
    logic retry;
`endif

    assign fe = clk_q & ~clk_s2;

    always_ff @(posedge clock_50) begin
        if (!resetn) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_q  <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk_in;
            clk_s2 <= clk_s1;
            clk_q  <= clk_s2;
            dat_s1 <= ps2_dat_in;
            dat_s2 <= dat_s1;
        end
    end

    always_ff @(posedge clock_50) begin
        if (!resetn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            cmd_busy   <= 1'b0;
            cmd_done   <= 1'b0;
            cmd_error  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry      <= 1'b0;
`endif
        end else begin
            cmd_done  <= 1'b0;
            cmd_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    cnt        <= '0;
`ifdef PS2_TX_RETRY_EN
                    retry      <= 1'b0;
`endif
                    if (cmd_send) begin
                        shreg      <= {~^cmd_data, cmd_data};
                        ps2_clk_oe <= 1'b1;
                        cmd_busy   <= 1'b1;
                        state      <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        ps2_dat_oe <= 1'b1;
                        cnt        <= '0;
                        state      <= S_START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_START: begin
                    ps2_clk_oe <= 1'b0;
                    bitcnt     <= '0;
                    cnt        <= '0;
                    state      <= S_SEND;
                end
                S_SEND: begin
                    // A falling edge takes priority over an expiring timeout.
                    if (fe) begin
                        cnt    <= '0;
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 4'd9) begin
                            ps2_dat_oe <= 1'b0;
                            state      <= S_WAIT_ACK;
                        end else begin
                            ps2_dat_oe <= ~shreg[bitcnt];
                        end
                    end else if (cnt == TO_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        state      <= S_FAIL;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (fe) begin
                        cnt <= '0;
                        if (!dat_s2) begin
                            state <= S_WAIT_IDLE;
                        end else begin
                            ps2_clk_oe <= 1'b0;
                            ps2_dat_oe <= 1'b0;
                            state      <= S_FAIL;
                        end
                    end else if (cnt == TO_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        state      <= S_FAIL;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (clk_s2 && dat_s2) begin
                        state <= S_DONE;
                    end else if (fe) begin
                        cnt <= '0;
                    end else if (cnt == TO_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        state      <= S_FAIL;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    cmd_done <= 1'b1;
                    cmd_busy <= 1'b0;
                    state    <= S_IDLE;
                end
                S_FAIL: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    cnt        <= '0;
`ifdef PS2_TX_RETRY_EN
                    if (!retry) begin
                        // First failure: silently restart the same byte.
                        retry      <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        state      <= S_INHIBIT;
                    end else begin
                        cmd_error <= 1'b1;
                        cmd_busy  <= 1'b0;
                        state     <= S_IDLE;
                    end
`else
                    cmd_error <= 1'b1;
                    cmd_busy  <= 1'b0;
                    state     <= S_IDLE;
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
